// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: default frame width, divider bounds
// and the frame sequencer state encoding.
package spi_pkg;

    localparam int SPI_M_DEFAULT   = 9;
    localparam int SPI_DIV_DEFAULT = 4;
    localparam int SPI_DIV_MIN     = 2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEAD = 3'd1,
        ST_HIGH = 3'd2,
        ST_LOW  = 3'd3,
        ST_END  = 3'd4,
        ST_GAP  = 3'd5
    } spi_state_t;

    // Cycles LOAD stays low for one frame.
    function automatic int spi_load_low_cycles(input int m, input int div);
        return div * (2 * m + 1);
    endfunction

endpackage

// File: rtl/spi_div_tick.sv
// Loadable down-counter that flags its terminal count; the FSM reloads it on
// every state change so each state lasts (load value + 1) cycles.
module spi_div_tick #(
    parameter int DW = 2
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          i_load,
    input  logic [DW-1:0] i_load_val,
    output logic          o_tick
);

    logic [DW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_tick = (r_cnt == '0);

endmodule

// File: rtl/spi_master.sv
// SPI master for the LOAD/SCLK/MOSI/MISO slave link: shifts one M-bit word each
// way per frame, MSB first, then raises LOAD so the slave latches and reloads.
module spi_master
    import spi_pkg::*;
#(
    parameter int M   = SPI_M_DEFAULT,
    parameter int DIV = SPI_DIV_DEFAULT
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         st,
    input  logic [M-1:0] DI,
    output logic [M-1:0] DO,
    output logic         BUSY,
    output logic         DONE,
    output logic         SCLK,
    output logic         LOAD,
    output logic         MOSI,
    input  logic         MISO,
    output spi_state_t   dbg_state
);

    localparam int BW = $clog2(M);
    localparam int DW = $clog2(DIV);

    spi_state_t     r_state;
    logic [M-1:0]   r_tx_sr;
    logic [M-1:0]   r_rx_sr;
    logic [BW-1:0]  r_bit;

    logic           w_tick;
    logic           w_div_load;
    logic [DW-1:0]  w_div_val;

    // Divider reload accompanies every state change; GAP is one cycle shorter
    // because END already counts toward the inter-frame spacing.
    always_comb begin
        w_div_load = 1'b0;
        w_div_val  = DW'(DIV - 1);
        case (r_state)
            ST_IDLE: w_div_load = st;
            ST_END: begin
                w_div_load = 1'b1;
                w_div_val  = DW'(DIV - 2);
            end
            default: w_div_load = w_tick;
        endcase
    end

    spi_div_tick #(
        .DW(DW)
    ) u_div (
        .clk       (clk),
        .clr       (clr),
        .i_load    (w_div_load),
        .i_load_val(w_div_val),
        .o_tick    (w_tick)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= ST_IDLE;
            r_tx_sr <= '0;
            r_rx_sr <= '0;
            r_bit   <= '0;
            DO      <= '0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            SCLK    <= 1'b0;
            LOAD    <= 1'b1;
            MOSI    <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (st) begin
                        r_tx_sr <= DI;
                        r_rx_sr <= '0;
                        r_bit   <= '0;
                        MOSI    <= DI[M-1];
                        LOAD    <= 1'b0;
                        BUSY    <= 1'b1;
                        r_state <= ST_LEAD;
                    end
                end
                ST_LEAD: begin
                    if (w_tick) begin
                        SCLK    <= 1'b1;
                        r_rx_sr <= {r_rx_sr[M-2:0], MISO};
                        r_state <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (w_tick) begin
                        SCLK    <= 1'b0;
                        r_tx_sr <= {r_tx_sr[M-2:0], 1'b0};
                        MOSI    <= r_tx_sr[M-2];
                        r_state <= ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (w_tick) begin
                        if (r_bit == BW'(M - 1)) begin
                            LOAD    <= 1'b1;
                            DO      <= r_rx_sr;
                            DONE    <= 1'b1;
                            r_state <= ST_END;
                        end else begin
                            r_bit   <= r_bit + 1'b1;
                            SCLK    <= 1'b1;
                            r_rx_sr <= {r_rx_sr[M-2:0], MISO};
                            r_state <= ST_HIGH;
                        end
                    end
                end
                ST_END: begin
                    r_state <= ST_GAP;
                end
                ST_GAP: begin
                    if (w_tick) begin
                        BUSY    <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign dbg_state = r_state;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: behavioural slave on each link, scoreboard of expected
// master/slave words per frame, and cycle-exact frame timing checks.
module tb_spi_master;
    import spi_pkg::*;

    localparam int M    = 9;
    localparam int DIV  = 4;
    localparam int DIV2 = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           clr = 1'b1;
    logic           st_drv = 1'b0;
    logic           use2 = 1'b0;
    logic [M-1:0]   DI = '0;
    logic           st, st2;

    logic [M-1:0]   DO, DO2;
    logic           BUSY, DONE, SCLK, LOAD, MOSI, MISO;
    logic           BUSY2, DONE2, SCLK2, LOAD2, MOSI2, MISO2;
    spi_state_t     dbg_state, dbg_state2;

    assign st  = st_drv & ~use2;
    assign st2 = st_drv & use2;

    spi_master #(.M(M), .DIV(DIV)) u_dut (
        .clk(clk), .clr(clr), .st(st), .DI(DI), .DO(DO), .BUSY(BUSY),
        .DONE(DONE), .SCLK(SCLK), .LOAD(LOAD), .MOSI(MOSI), .MISO(MISO),
        .dbg_state(dbg_state)
    );

    spi_master #(.M(M), .DIV(DIV2)) u_dut2 (
        .clk(clk), .clr(clr), .st(st2), .DI(DI), .DO(DO2), .BUSY(BUSY2),
        .DONE(DONE2), .SCLK(SCLK2), .LOAD(LOAD2), .MOSI(MOSI2), .MISO(MISO2),
        .dbg_state(dbg_state2)
    );

    // Slave model: samples MOSI on SCLK rise, shifts MISO on fall, latches on LOAD rise.
    logic [M-1:0] s_tx = '0, s_rx = '0, s_rcv = '0, s_di = '0;
    always @(posedge LOAD) begin s_rcv = s_rx; s_tx = s_di; end
    always @(posedge SCLK) if (LOAD === 1'b0) s_rx = {s_rx[M-2:0], MOSI};
    always @(negedge SCLK) if (LOAD === 1'b0) s_tx = {s_tx[M-2:0], 1'b0};
    assign MISO = s_tx[M-1];

    logic [M-1:0] s2_tx = '0, s2_rx = '0, s2_rcv = '0, s2_di = '0;
    always @(posedge LOAD2) begin s2_rcv = s2_rx; s2_tx = s2_di; end
    always @(posedge SCLK2) if (LOAD2 === 1'b0) s2_rx = {s2_rx[M-2:0], MOSI2};
    always @(negedge SCLK2) if (LOAD2 === 1'b0) s2_tx = {s2_tx[M-2:0], 1'b0};
    assign MISO2 = s2_tx[M-1];

    wire          m_load = use2 ? LOAD2 : LOAD;
    wire          m_sclk = use2 ? SCLK2 : SCLK;
    wire          m_busy = use2 ? BUSY2 : BUSY;
    wire          m_done = use2 ? DONE2 : DONE;
    wire [M-1:0]  m_do   = use2 ? DO2 : DO;
    wire [M-1:0]  m_rcv  = use2 ? s2_rcv : s_rcv;
    wire [M-1:0]  m_stx  = use2 ? s2_tx : s_tx;

    int checks = 0;
    int failures = 0;
    logic [M-1:0] exp_q[$];
    logic [M-1:0] exp_s_q[$];

    // One full frame with timing checks; st is re-pulsed at cycles pa/pb (0 = never).
    task automatic run_frame(input logic [M-1:0] din, input int pa, input int pb, input string tag);
        int cyc, done_cyc, done_cnt, load_low, rises, busy_last, r1, r2, dv;
        logic prev_sclk;
        logic [M-1:0] e_do, e_rcv;
        dv = use2 ? DIV2 : DIV;
        @(posedge clk); #1;
        DI = din;
        st_drv = 1'b1;
        exp_q.push_back(m_stx);
        exp_s_q.push_back(din);
        @(posedge clk); #1;
        st_drv = 1'b0;
        cyc = 1; done_cyc = 0; done_cnt = 0; load_low = 0; rises = 0;
        busy_last = 0; r1 = 0; r2 = 0; prev_sclk = 1'b0;
        checks++;
        if (m_load !== 1'b0 || m_busy !== 1'b1) begin
            failures++;
            $display("FAIL %s start load=%b busy=%b exp load=0 busy=1", tag, m_load, m_busy);
        end
        while (cyc < 300) begin
            if (m_load === 1'b0) load_low++;
            if (m_sclk === 1'b1 && prev_sclk === 1'b0) begin
                rises++;
                if (r1 == 0) r1 = cyc;
                else if (r2 == 0) r2 = cyc;
            end
            prev_sclk = m_sclk;
            if (m_busy === 1'b1) busy_last = cyc;
            if (m_done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL %s unexpected DONE at cycle %0d", tag, cyc);
                end else begin
                    e_do  = exp_q.pop_front();
                    e_rcv = exp_s_q.pop_front();
                    checks++;
                    if (m_do !== e_do) begin
                        failures++;
                        $display("FAIL %s DO got=%h exp=%h", tag, m_do, e_do);
                    end
                    checks++;
                    if (m_rcv !== e_rcv) begin
                        failures++;
                        $display("FAIL %s slave_rx got=%h exp=%h", tag, m_rcv, e_rcv);
                    end
                end
            end
            if (m_busy !== 1'b1) break;
            st_drv = (cyc == pa || cyc == pb);
            @(posedge clk); #1;
            cyc++;
        end
        st_drv = 1'b0;
        checks++;
        if (done_cnt != 1 || done_cyc != 1 + dv * (2 * M + 1)) begin
            failures++;
            $display("FAIL %s done cnt=%0d cyc=%0d exp cnt=1 cyc=%0d", tag, done_cnt, done_cyc, 1 + dv * (2 * M + 1));
        end
        checks++;
        if (load_low != spi_load_low_cycles(M, dv)) begin
            failures++;
            $display("FAIL %s load_low got=%0d exp=%0d", tag, load_low, dv * (2 * M + 1));
        end
        checks++;
        if (rises != M || r1 != 1 + dv || r2 - r1 != 2 * dv) begin
            failures++;
            $display("FAIL %s sclk rises=%0d first=%0d period=%0d exp %0d/%0d/%0d", tag, rises, r1, r2 - r1, M, 1 + dv, 2 * dv);
        end
        checks++;
        if (busy_last != dv * (2 * M + 2)) begin
            failures++;
            $display("FAIL %s busy_last got=%0d exp=%0d", tag, busy_last, dv * (2 * M + 2));
        end
    endtask

    task automatic test_reset();
        clr = 1'b1;
        st_drv = 1'b1;
        DI = 9'h1FF;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (SCLK !== 1'b0 || LOAD !== 1'b1 || MOSI !== 1'b0 || DO !== '0 || BUSY !== 1'b0
            || DONE !== 1'b0 || dbg_state !== ST_IDLE || BUSY2 !== 1'b0 || dbg_state2 !== ST_IDLE) begin
            failures++;
            $display("FAIL reset sclk=%b load=%b mosi=%b do=%h busy=%b done=%b st=%0d",
                     SCLK, LOAD, MOSI, DO, BUSY, DONE, dbg_state);
        end
        clr = 1'b0;
        st_drv = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (BUSY !== 1'b0 || LOAD !== 1'b1) begin
            failures++;
            $display("FAIL reset_release busy=%b load=%b exp busy=0 load=1", BUSY, LOAD);
        end
    endtask

    task automatic test_basic();
        s_tx = 9'h0C3;
        s_di = 9'h0C3;
        run_frame(9'h1A5, 0, 0, "basic");
    endtask

    task automatic test_patterns();
        logic [M-1:0] pats[4];
        pats = '{9'h000, 9'h1FF, 9'h155, 9'h0AA};
        for (int i = 0; i < 4; i++) begin
            s_di = M'($urandom_range(0, (1 << M) - 1));
            run_frame(pats[i], 0, 0, "pattern");
        end
    endtask

    task automatic test_busy_start();
        s_di = 9'h13C;
        run_frame(9'h0F0, 10, 77, "busy_ignore");
        run_frame(9'h10F, 0, 0, "busy_next");
    endtask

    task automatic test_mid_reset();
        int seen;
        s_di = 9'h066;
        @(posedge clk); #1;
        DI = 9'h17E;
        st_drv = 1'b1;
        @(posedge clk); #1;
        st_drv = 1'b0;
        repeat (39) @(posedge clk);
        #1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        checks++;
        if (LOAD !== 1'b1 || SCLK !== 1'b0 || DO !== '0 || BUSY !== 1'b0 || DONE !== 1'b0
            || dbg_state !== ST_IDLE) begin
            failures++;
            $display("FAIL mid_reset load=%b sclk=%b do=%h busy=%b done=%b", LOAD, SCLK, DO, BUSY, DONE);
        end
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (DONE === 1'b1 || BUSY === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL mid_reset_quiet activity=%0d exp=0", seen);
        end
        s_di = 9'h0D2;
        run_frame(9'h0B9, 0, 0, "after_reset");
    endtask

    task automatic test_min_div();
        use2 = 1'b1;
        s2_tx = 9'h0C3;
        s2_di = 9'h0C3;
        run_frame(9'h1A5, 0, 0, "min_div");
        use2 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_patterns();
        test_busy_start();
        test_mid_reset();
        test_min_div();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_master.md
# spi_master

Single-clock SPI master that drives the 9-bit LOAD/SCLK/MOSI/MISO link served by the team's SPI slave, from the other end. Per frame it shifts one word out on MOSI (MSB first) and captures the slave's word from MISO. It then raises LOAD so the slave latches what it received and reloads its transmit register. It sits on the system side of the board link and is started by a one-cycle strobe from local control logic.

## Interface
- `M`, 9: frame/word width in bits.
- `DIV`, 4: system-clock cycles per SCLK half-period; legal range ≥2.
- `clk` in 1: system clock; all logic on posedge.
- `clr` in 1: reset, synchronous, active-high.
- `st` in 1: start strobe; sampled only in IDLE.
- `DI` in M: word to transmit; captured on accepted `st`.
- `DO` out M: last received word; updated at frame end.
- `BUSY` out 1: high from the cycle after an accepted `st` through the end of GAP.
- `DONE` out 1: one-cycle pulse at frame end.
- `SCLK` out 1: serial clock to slave; idle low.
- `LOAD` out 1: frame delimiter to slave; high = idle/load, low = shifting.
- `MOSI` out 1: serial data to slave.
- `MISO` in 1: serial data from slave.

## Operation
- All outputs registered. Reset values: SCLK=0, LOAD=1, MOSI=0, DO=0, BUSY=0, DONE=0; state=IDLE; internal shift registers and counters cleared.
- States:
  - IDLE: LOAD=1, SCLK=0. On `st`, capture DI→tx_sr, clear rx_sr, go to LEAD.
  - LEAD (DIV cycles): LOAD=0, SCLK=0, MOSI=tx_sr[M-1]. Then go to HIGH.
  - HIGH (DIV cycles): SCLK=1. rx_sr ← {rx_sr[M-2:0], MISO}, sampled in the same cycle SCLK is registered 0→1. Then go to LOW.
  - LOW (DIV cycles): SCLK=0. On entry, tx_sr shifts left and MOSI takes the next bit. After M HIGH/LOW pairs (bit counter = M-1 at end of LOW), go to END; otherwise go to HIGH.
  - END (1 cycle): LOAD=1, DO←rx_sr, DONE=1. Then go to GAP.
  - GAP (DIV-1 cycles): LOAD=1, BUSY=1. Then go to IDLE.
- The slave samples MOSI on SCLK rise and shifts MISO on SCLK fall. MOSI therefore changes only on SCLK fall or at LEAD entry, and MISO is stable for DIV cycles before each sample. MISO needs no synchronizer.
- The word received from the slave is the value on its DI at the previous LOAD rising edge, i.e. the end of the prior frame.
- `st` outside IDLE is ignored and not queued. `st` in the same cycle as `clr`: `clr` wins.
- `clr` mid-frame: the next cycle has LOAD=1, SCLK=0, state=IDLE, and DO=0 with no DONE pulse. The resulting LOAD rise makes the slave latch a partial word; upper logic must discard it.
- Bit counter is $clog2(M) bits. Divider counter is $clog2(DIV) bits and is reloaded on every state change.

## Timing
- Accepted `st` at cycle 0: LOAD falls at cycle 1. The first SCLK rise is at 1+DIV.
- LOAD is low for DIV·(2M+1) cycles: 76 with defaults.
- DONE and the LOAD rise occur at cycle 1+DIV·(2M+1), i.e. 77 with defaults.
- BUSY falls DIV cycles after DONE. The earliest next accepted `st` comes 1 cycle later: frame-to-frame period 2+DIV·(2M+2) cycles.
- LOAD is high ≥DIV cycles between frames.
- SCLK has exactly M rising edges per frame, with 50% duty cycle and period 2·DIV.

## Structure
- Shared package `spi_pkg`: default M=9, DIV minimum, state enum (IDLE, LEAD, HIGH, LOW, END, GAP).
- One sub-module, `spi_div_tick`: loadable down-counter producing a terminal-count tick every DIV cycles. It is reloaded by the FSM.
- The top holds the FSM, tx_sr, rx_sr, bit counter and output registers.

## Test plan
- Setup for all scenarios: behavioural slave model on the link.
- Basic exchange: slave preloaded 9'h0C3; DI=9'h1A5 → master DO=9'h0C3 and slave received 9'h1A5. DONE high 1 cycle at cycle 77. Exactly 9 SCLK rises; LOAD low 76 cycles.
- Patterns: consecutive frames with DI=9'h000, 9'h1FF, 9'h155, 9'h0AA → each frame's DO equals the slave word loaded at the previous LOAD rise. No bit slip.
- Start while busy: pulse `st` at cycles 10 and 77 after an accepted start → neither starts a frame. BUSY stays high until cycle 81, and the next `st` at 82 is accepted.
- Mid-frame reset: `clr` at cycle 40 → LOAD=1, SCLK=0, DO=0, BUSY=0 next cycle, no DONE. A following frame completes correctly.
- Minimum divider: DIV=2, basic exchange → LOAD low 38 cycles, SCLK period 4 cycles, data correct.
- Reset values: hold `clr` with `st`=1 → all outputs at reset values and no frame starts.
